div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one multi-cycle 32-bit divider between two requesters, e.g. two issue slots or the EX stage plus a coprocessor path.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the divider's start/ready/annul handshake.
- Returns the 64-bit result tagged with the requester ID.
- Flush of the owning requester aborts the operation and drains the divider back to its free state.

Parameters:
- DRAIN_CYCLES, 3: cycles with start low and annul high after a cancel, before a new grant.
- RR_INIT, 0: requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req0_valid_i  in  1  requester 0 has a divide pending
- req0_signed_i  in  1  requester 0 signed divide
- req0_op1_i  in  32  requester 0 dividend
- req0_op2_i  in  32  requester 0 divisor
- req0_flush_i  in  1  requester 0 kills its in-flight divide
- req0_ack_o  out  1  requester 0 request accepted this cycle
- req1_valid_i, req1_signed_i, req1_op1_i, req1_op2_i, req1_flush_i, req1_ack_o: same for requester 1
- resp_valid_o  out  1  one-cycle result pulse
- resp_id_o  out  1  owner of the result
- resp_result_o  out  64  {remainder[63:32], quotient[31:0]}
- busy_o  out  1  arbiter not in IDLE
- div_signed_o  out  1  to divider
- div_op1_o  out  32  to divider
- div_op2_o  out  32  to divider
- div_start_o  out  1  to divider
- div_annul_o  out  1  to divider
- div_result_i  in  64  from divider
- div_ready_i  in  1  from divider, result valid

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: all outputs 0, state IDLE, priority pointer = RR_INIT, latched operands 0.
- States: IDLE, RUN, RELEASE, CANCEL.
- IDLE:
  - Grant when any reqN_valid_i is high.
  - If both are high, the requester not granted last wins; the pointer updates on every grant.
  - reqN_ack_o is combinational and high only for the winner, in IDLE only; the requester may drop valid the next cycle.
  - A request with its own flush high in the same cycle is not granted.
  - Latch signed/op1/op2/id. Next state RUN.
- RUN:
  - div_start_o = 1; div_op*/div_signed_o driven from the latches.
  - These outputs stay stable for the whole of RUN; the divider samples operands again at its final sign-fix step.
  - On div_ready_i = 1:
    - resp_valid_o pulses 1 cycle, with resp_result_o = div_result_i and resp_id_o = owner.
    - Next state RELEASE.
- RELEASE:
  - div_start_o = 0 for exactly 1 cycle so the divider returns to free; then IDLE.
  - Minimum back-to-back spacing: grant, RUN, RELEASE, next grant.
- Flush in RUN (owner's flush high, ready low):
  - div_start_o = 0 and div_annul_o = 1 from the next cycle, for DRAIN_CYCLES cycles (state CANCEL); no response is produced; then IDLE.
  - div_annul_o = 0 in all other states.
- Flush from the non-owner: ignored.
- Flush and div_ready_i in the same RUN cycle: flush wins; result discarded, no resp_valid_o; go to CANCEL.
- Flush while in RELEASE/CANCEL: no effect.
- Divide by zero:
  - Passed to the divider like any other operation; the arbiter does not inspect op2.
  - Result is whatever the divider returns: 64'd0.
- Latency:
  - The request sees 1 cycle from ack to RUN.
  - Total latency = divider latency + 1.
- Reset mid-operation: returns to IDLE immediately, no response. Since reset also clears the divider, no drain is needed.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: DIV_ZERO_FASTPATH_EN.
- Defined:
  - A granted request with op2 = 0 skips the divider: div_start_o stays 0.
  - resp_valid_o is asserted the cycle after ack with resp_result_o = 64'd0; then IDLE.
- Undefined: zero divisors go through the divider as above.

Test Plan:
- Single request: req0 unsigned 100/7 -> ack in cycle 0, later one resp pulse with id 0, result {32'd2, 32'd14}; start low for 1 cycle after ready.
- Signed request: req1 signed -7/2 -> resp id 1, result {32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quot -3).
- Round-robin: both valid continuously, RR_INIT = 0 -> grants alternate 0,1,0,1; each response carries the matching id and operands 20/3 vs 9/4.
- Owner flush mid-RUN: req0 issues 1000/3, flush 5 cycles later -> no resp; annul high and start low for 3 cycles; pending req1 granted in the next IDLE cycle.
- Flush coincident with div_ready_i -> resp_valid_o stays 0; CANCEL entered. Non-owner flush -> no effect; result delivered.
- Divide by zero, 5/0:
  - Macro off: resp result 64'd0 via the divider.
  - Macro on: resp one cycle after ack, div_start_o never asserted.

Source files
------------

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one multi-cycle 32-bit divider between two requesters
// Optional: DIV_ZERO_FASTPATH_EN answers zero-divisor requests directly, without starting the divider.
module div_arbiter #(
    parameter int DRAIN_CYCLES = 3,
    parameter bit RR_INIT      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    input  logic        req0_signed_i,
    input  logic [31:0] req0_op1_i,
    input  logic [31:0] req0_op2_i,
    input  logic        req0_flush_i,
    output logic        req0_ack_o,
    input  logic        req1_valid_i,
    input  logic        req1_signed_i,
    input  logic [31:0] req1_op1_i,
    input  logic [31:0] req1_op2_i,
    input  logic        req1_flush_i,
    output logic        req1_ack_o,
    output logic        resp_valid_o,
    output logic        resp_id_o,
    output logic [63:0] resp_result_o,
    output logic        busy_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_CANCEL,
        S_ZERO
    } state_t;

    state_t          state_q, state_d;
    logic            prio_q;
    logic            owner_q;
    logic            signed_q;
    logic [31:0]     op1_q;
    logic [31:0]     op2_q;
    logic [CW-1:0]   cnt_q;

    logic            elig0, elig1;
    logic            grant_any;
    logic            grant_id;
    logic            grant_signed;
    logic [31:0]     grant_op1;
    logic [31:0]     grant_op2;
    logic            owner_flush;

    // A requester flushing in the same cycle is not eligible for a grant.
    assign elig0        = req0_valid_i & ~req0_flush_i;
    assign elig1        = req1_valid_i & ~req1_flush_i;
    assign grant_any    = elig0 | elig1;
    assign grant_id     = (elig0 & elig1) ? prio_q : elig1;
    assign grant_signed = grant_id ? req1_signed_i : req0_signed_i;
    assign grant_op1    = grant_id ? req1_op1_i : req0_op1_i;
    assign grant_op2    = grant_id ? req1_op2_i : req0_op2_i;
    assign owner_flush  = owner_q ? req1_flush_i : req0_flush_i;

    always_comb begin
        state_d       = state_q;
        req0_ack_o    = 1'b0;
        req1_ack_o    = 1'b0;
        resp_valid_o  = 1'b0;
        resp_result_o = 64'd0;
        div_start_o   = 1'b0;
        div_annul_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    req0_ack_o = ~grant_id;
                    req1_ack_o = grant_id;
`ifdef DIV_ZERO_FASTPATH_EN
                    state_d = (grant_op2 == 32'd0) ? S_ZERO : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                div_start_o = 1'b1;
                // Flush beats a coincident ready: the result is dropped.
                if (owner_flush) begin
                    state_d = S_CANCEL;
                end else if (div_ready_i) begin
                    resp_valid_o  = 1'b1;
                    resp_result_o = div_result_i;
                    state_d       = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            S_CANCEL: begin
                div_annul_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_ZERO: begin
                resp_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prio_q   <= RR_INIT;
            owner_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == S_CANCEL) ? cnt_q + 1'b1 : '0;
            if (state_q == S_IDLE && grant_any) begin
                owner_q  <= grant_id;
                prio_q   <= ~grant_id;
                signed_q <= grant_signed;
                op1_q    <= grant_op1;
                op2_q    <= grant_op2;
            end
        end
    end

    // Operands come straight from the latches so they hold through the divider's final sign fix.
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign resp_id_o    = owner_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter with a behavioural divider and scoreboard
module tb_div_arbiter;

    localparam int DIV_LAT = 8;
    localparam int DRAIN   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_signed, req0_flush, req0_ack;
    logic [31:0] req0_op1, req0_op2;
    logic        req1_valid, req1_signed, req1_flush, req1_ack;
    logic [31:0] req1_op1, req1_op2;
    logic        resp_valid, resp_id, busy;
    logic [63:0] resp_result;
    logic        div_signed, div_start, div_annul, div_ready;
    logic [31:0] div_op1, div_op2;
    logic [63:0] div_result;

    int total = 0;
    int bad   = 0;
    int resp_cnt  = 0;
    int start_cnt = 0;

    typedef struct {
        logic        id;
        logic [63:0] res;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    div_arbiter #(.DRAIN_CYCLES(DRAIN), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_signed_i(req0_signed), .req0_op1_i(req0_op1),
        .req0_op2_i(req0_op2), .req0_flush_i(req0_flush), .req0_ack_o(req0_ack),
        .req1_valid_i(req1_valid), .req1_signed_i(req1_signed), .req1_op1_i(req1_op1),
        .req1_op2_i(req1_op2), .req1_flush_i(req1_flush), .req1_ack_o(req1_ack),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_result_o(resp_result),
        .busy_o(busy), .div_signed_o(div_signed), .div_op1_o(div_op1), .div_op2_o(div_op2),
        .div_start_o(div_start), .div_annul_o(div_annul),
        .div_result_i(div_result), .div_ready_i(div_ready)
    );

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural divider: busy for DIV_LAT cycles after start, one-cycle ready, frees when start drops.
    int dv_st  = 0;
    int dv_cnt = 0;
    always @(posedge clk) begin
        if (rst || div_annul) begin
            dv_st      <= 0;
            div_ready  <= 1'b0;
            div_result <= 64'd0;
        end else begin
            case (dv_st)
                0: begin
                    div_ready <= 1'b0;
                    if (div_start) begin
                        dv_st  <= 1;
                        dv_cnt <= DIV_LAT;
                    end
                end
                1: begin
                    if (dv_cnt == 1) begin
                        div_ready  <= 1'b1;
                        div_result <= ref_div(div_signed, div_op1, div_op2);
                        dv_st      <= 2;
                    end else begin
                        dv_cnt <= dv_cnt - 1;
                    end
                end
                default: begin
                    div_ready <= 1'b0;
                    if (!div_start) dv_st <= 0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (div_start) start_cnt <= start_cnt + 1;
    end

    task automatic clear_inputs;
        req0_valid = 0; req0_signed = 0; req0_op1 = 0; req0_op2 = 0; req0_flush = 0;
        req1_valid = 0; req1_signed = 0; req1_op1 = 0; req1_op2 = 0; req1_flush = 0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_resp(output bit got, output logic id, output logic [63:0] res);
        got = 0;
        id  = 0;
        res = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                id  = resp_id;
                res = resp_result;
            end else begin
                next_cycle();
            end
        end
    endtask

    task automatic test_reset;
        int r0;
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        total++;
        if ({req0_ack, req1_ack, resp_valid, resp_id, resp_result, busy, div_signed,
             div_op1, div_op2, div_start, div_annul} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b start=%b op1=%h op2=%h resp=%b want all 0",
                     busy, div_start, div_op1, div_op2, resp_valid);
        end
        next_cycle();
        rst = 1'b0;
        req0_valid = 1; req0_op1 = 77; req0_op2 = 5;
        next_cycle();
        req0_valid = 0;
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        r0 = resp_cnt;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || div_start !== 1'b0 || div_op1 !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_op: busy=%b start=%b op1=%h want 0 0 0", busy, div_start, div_op1);
        end
        repeat (20) next_cycle();
        total++;
        if (resp_cnt !== r0) begin
            bad++;
            $display("FAIL reset_no_resp: responses=%0d want 0", resp_cnt - r0);
        end
    endtask

    task automatic test_single;
        bit got;
        logic id;
        logic [63:0] res;
        do_reset();
        req0_valid = 1; req0_signed = 0; req0_op1 = 100; req0_op2 = 7;
        @(negedge clk);
        total++;
        if (req0_ack !== 1'b1 || req1_ack !== 1'b0) begin
            bad++;
            $display("FAIL single_ack: ack0=%b ack1=%b want 1 0", req0_ack, req1_ack);
        end
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        total++;
        if (div_start !== 1'b1 || div_op1 !== 32'd100 || div_op2 !== 32'd7 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_run: start=%b op1=%0d op2=%0d busy=%b want 1 100 7 1",
                     div_start, div_op1, div_op2, busy);
        end
        wait_resp(got, id, res);
        total++;
        if (!got || id !== 1'b0 || res !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL single_resp: got=%0d id=%b res=%h want 1 0 %h", got, id, res, {32'd2, 32'd14});
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (div_start !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_release: start=%b busy=%b want 0 1", div_start, busy);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_signed;
        bit got;
        logic id;
        logic [63:0] res;
        do_reset();
        req1_valid = 1; req1_signed = 1; req1_op1 = 32'hFFFF_FFF9; req1_op2 = 32'd2;
        @(negedge clk);
        total++;
        if (req1_ack !== 1'b1 || req0_ack !== 1'b0) begin
            bad++;
            $display("FAIL signed_ack: ack0=%b ack1=%b want 0 1", req0_ack, req1_ack);
        end
        next_cycle();
        req1_valid = 0;
        wait_resp(got, id, res);
        total++;
        if (!got || id !== 1'b1 || res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            bad++;
            $display("FAIL signed_resp: got=%0d id=%b res=%h want 1 1 ffffffff_fffffffd", got, id, res);
        end
    endtask

    task automatic test_round_robin;
        int grants = 0;
        int resps  = 0;
        exp_t e;
        do_reset();
        req0_valid = 1; req0_op1 = 20; req0_op2 = 3;
        req1_valid = 1; req1_op1 = 9;  req1_op2 = 4;
        for (int c = 0; c < 300 && resps < 4; c++) begin
            @(negedge clk);
            if (req0_ack || req1_ack) begin
                total++;
                if ((req0_ack && req1_ack) || req1_ack !== ((grants % 2) == 1)) begin
                    bad++;
                    $display("FAIL rr_order: grant#%0d ack0=%b ack1=%b want id %0d",
                             grants, req0_ack, req1_ack, grants % 2);
                end
                e.id  = ((grants % 2) == 1);
                e.res = e.id ? {32'd1, 32'd2} : {32'd2, 32'd6};
                exp_q.push_back(e);
                grants++;
            end
            if (resp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rr_resp: unexpected response id=%b res=%h want none", resp_id, resp_result);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_id !== e.id || resp_result !== e.res) begin
                        bad++;
                        $display("FAIL rr_resp: id=%b res=%h want %b %h", resp_id, resp_result, e.id, e.res);
                    end
                end
                resps++;
            end
            next_cycle();
            if (grants >= 4) begin
                req0_valid = 0;
                req1_valid = 0;
            end
        end
        total++;
        if (grants != 4 || resps != 4) begin
            bad++;
            $display("FAIL rr_count: grants=%0d resps=%0d want 4 4", grants, resps);
        end
    endtask

    task automatic test_owner_flush;
        int r0;
        bit got;
        logic id;
        logic [63:0] res;
        do_reset();
        req0_valid = 1; req0_op1 = 1000; req0_op2 = 3;
        @(negedge clk);
        total++;
        if (req0_ack !== 1'b1) begin
            bad++;
            $display("FAIL flush_ack0: ack0=%b want 1", req0_ack);
        end
        r0 = resp_cnt;
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            req0_valid = 0;
            req1_valid = 1; req1_op1 = 9; req1_op2 = 4;
            req0_flush = (c == 5);
            @(negedge clk);
            total++;
            if (c <= 5) begin
                if (div_start !== 1'b1 || div_annul !== 1'b0 || req1_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_run c%0d: start=%b annul=%b ack1=%b want 1 0 0",
                             c, div_start, div_annul, req1_ack);
                end
            end else if (c <= 5 + DRAIN) begin
                if (div_start !== 1'b0 || div_annul !== 1'b1 || req1_ack !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL flush_drain c%0d: start=%b annul=%b ack1=%b busy=%b want 0 1 0 1",
                             c, div_start, div_annul, req1_ack, busy);
                end
            end else begin
                if (req1_ack !== 1'b1 || div_annul !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_regrant c%0d: ack1=%b annul=%b want 1 0", c, req1_ack, div_annul);
                end
            end
        end
        total++;
        if (resp_cnt !== r0) begin
            bad++;
            $display("FAIL flush_no_resp: responses=%0d want 0", resp_cnt - r0);
        end
        next_cycle();
        req1_valid = 0;
        wait_resp(got, id, res);
        total++;
        if (!got || id !== 1'b1 || res !== {32'd1, 32'd2}) begin
            bad++;
            $display("FAIL flush_next_resp: got=%0d id=%b res=%h want 1 1 %h", got, id, res, {32'd1, 32'd2});
        end
    endtask

    task automatic test_flush_edges;
        bit seen = 0;
        int r0;
        bit got;
        logic id;
        logic [63:0] res;
        do_reset();
        req0_valid = 1; req0_op1 = 12345; req0_op2 = 11;
        next_cycle();
        req0_valid = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (div_ready) seen = 1;
            else next_cycle();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL flush_ready_timeout: div_ready never seen want 1");
        end else begin
            req0_flush = 1;
            #1;
            if (resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_ready_resp: resp_valid=%b want 0", resp_valid);
            end
            r0 = resp_cnt;
            next_cycle();
            req0_flush = 0;
            @(negedge clk);
            total++;
            if (div_annul !== 1'b1 || div_start !== 1'b0) begin
                bad++;
                $display("FAIL flush_ready_cancel: annul=%b start=%b want 1 0", div_annul, div_start);
            end
            repeat (DRAIN + 1) next_cycle();
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || resp_cnt !== r0) begin
                bad++;
                $display("FAIL flush_ready_drain: busy=%b responses=%0d want 0 0", busy, resp_cnt - r0);
            end
        end
        next_cycle();
        req0_valid = 1; req0_op1 = 50; req0_op2 = 5;
        next_cycle();
        req0_valid = 0;
        req1_flush = 1;
        wait_resp(got, id, res);
        req1_flush = 0;
        total++;
        if (!got || id !== 1'b0 || res !== {32'd0, 32'd10}) begin
            bad++;
            $display("FAIL nonowner_flush: got=%0d id=%b res=%h want 1 0 %h", got, id, res, {32'd0, 32'd10});
        end
    endtask

    task automatic test_div_zero;
        int s0;
        bit got;
        logic id;
        logic [63:0] res;
        do_reset();
        s0 = start_cnt;
        req0_valid = 1; req0_op1 = 5; req0_op2 = 0;
        @(negedge clk);
        total++;
        if (req0_ack !== 1'b1) begin
            bad++;
            $display("FAIL zero_ack: ack0=%b want 1", req0_ack);
        end
        next_cycle();
        req0_valid = 0;
`ifdef DIV_ZERO_FASTPATH_EN
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_result !== 64'd0 || resp_id !== 1'b0 || div_start !== 1'b0) begin
            bad++;
            $display("FAIL zero_fast: valid=%b res=%h id=%b start=%b want 1 0 0 0",
                     resp_valid, resp_result, resp_id, div_start);
        end
        repeat (5) next_cycle();
        total++;
        if (start_cnt !== s0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_fast_nostart: starts=%0d busy=%b want 0 0", start_cnt - s0, busy);
        end
`else
        wait_resp(got, id, res);
        total++;
        if (!got || id !== 1'b0 || res !== 64'd0 || start_cnt == s0) begin
            bad++;
            $display("FAIL zero_divider: got=%0d id=%b res=%h starts=%0d want 1 0 0 >0",
                     got, id, res, start_cnt - s0);
        end
`endif
    endtask

    task automatic test_random;
        bit   pend[2];
        bit   acked[2];
        logic sg[2];
        logic [31:0] a[2], b[2];
        bit   prio = 1'b0;
        bit   w;
        exp_t e;
        do_reset();
        pend = '{0, 0};
        acked = '{0, 0};
        for (int c = 0; c < 1200; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (acked[k]) pend[k] = 0;
                acked[k] = 0;
                if (!pend[k] && c < 1000 && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1;
                    sg[k]   = 1'($urandom_range(0, 1));
                    a[k]    = $urandom;
                    b[k]    = ($urandom_range(0, 7) == 0) ? 32'd0 :
                              ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
                end
            end
            req0_valid = pend[0]; req0_signed = sg[0]; req0_op1 = a[0]; req0_op2 = b[0];
            req1_valid = pend[1]; req1_signed = sg[1]; req1_op1 = a[1]; req1_op2 = b[1];
            @(negedge clk);
            if (req0_ack || req1_ack) begin
                w = (pend[0] && pend[1]) ? prio : pend[1];
                total++;
                if ((req0_ack && req1_ack) || req1_ack !== w) begin
                    bad++;
                    $display("FAIL rand_grant c%0d: ack0=%b ack1=%b want id %0d", c, req0_ack, req1_ack, w);
                end
                prio = ~w;
                acked[w] = 1;
                e.id  = w;
                e.res = ref_div(sg[w], a[w], b[w]);
                exp_q.push_back(e);
            end
            if (resp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_resp c%0d: unexpected id=%b res=%h want none", c, resp_id, resp_result);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_id !== e.id || resp_result !== e.res) begin
                        bad++;
                        $display("FAIL rand_resp c%0d: id=%b res=%h want %b %h",
                                 c, resp_id, resp_result, e.id, e.res);
                    end
                end
            end
            next_cycle();
        end
        total++;
        if (exp_q.size() != 0 || pend[0] || pend[1]) begin
            bad++;
            $display("FAIL rand_drain: outstanding=%0d pend=%b%b want 0 00", exp_q.size(), pend[1], pend[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_signed();
        test_round_robin();
        test_owner_flush();
        test_flush_edges();
        test_div_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
